coeff_load_sequencer: RTL and testbench
=======================================

Name: coeff_load_sequencer

Overview:
- Sits directly upstream of the FIR datapath controller and drives its load-coefficient strobe.
- When the bus-side register block raises new_coefficient_set, it issues one load_coeff strobe for each of the four coefficients F0..F3, in order.
- It waits on the controller's modwait handshake between strobes, then pulses clear_new_coeff so the register block clears its flag.
- It also drives coefficient_num, which selects the coefficient register feeding the datapath.

Parameters:
- NUM_COEFFS, 4, coefficients per set; fixed at 4; coefficient_num width is 2.
- TIMEOUT_CYCLES, 16, maximum consecutive cycles modwait may stay high in a WAIT state; used only with the optional feature.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset: one clock; reset is asynchronous and active-high.
- new_coefficient_set  input  1  level flag from the register block: a new set of 4 coefficients is written.
- modwait  input  1  busy flag from the FIR controller; high while it is processing a sample or latching a coefficient.
- load_coeff  output  1  one-cycle strobe to the controller to latch the coefficient selected by coefficient_num.
- coefficient_num  output  2  index (0..3) of the coefficient being loaded; mux select for the coefficient registers.
- clear_new_coeff  output  1  one-cycle pulse asking the register block to clear new_coefficient_set.
- busy  output  1  high in every state except IDLE.
- load_err  output  1  timeout error flag; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset values: state=IDLE, load_coeff=0, coefficient_num=0, clear_new_coeff=0, busy=0, load_err=0, timeout counter=0. Reset mid-sequence abandons the set without any clear_new_coeff pulse.
- Outputs are Moore, decoded from the registered state only. There is no combinational path from any input to any output.
- States: IDLE, LOAD0, WAIT0, LOAD1, WAIT1, LOAD2, WAIT2, LOAD3, WAIT3, DONE, ERR.
- IDLE:
  - Goes to LOAD0 when new_coefficient_set=1 and modwait=0.
  - If modwait=1 (a sample is in flight), stays in IDLE; load_coeff is never issued while modwait is high.
- LOADn:
  - load_coeff=1, coefficient_num=n.
  - Unconditionally goes to WAITn next cycle. The controller samples the strobe on that edge and raises modwait in the following cycle.
- WAITn:
  - load_coeff=0; coefficient_num held at n.
  - When modwait=0: goes to LOAD(n+1) for n<3, or to DONE for n=3.
  - Otherwise stays in WAITn.
- DONE:
  - clear_new_coeff=1 for exactly one cycle; coefficient_num held at 3; then IDLE.
  - If new_coefficient_set is still 1 in the cycle after DONE (register block slow to clear), IDLE restarts a full sequence.
- new_coefficient_set dropping mid-sequence is ignored; the sequence runs to DONE.
- new_coefficient_set rising during a sequence is not queued. The register block rewrites and re-asserts it after the clear.
- Latency: first strobe 1 cycle after start qualifies. With minimum 1-cycle modwait per coefficient, IDLE→DONE takes 8 cycles, and clear_new_coeff fires in cycle 9.
- ERR: load_err=1, busy=1. Stays in ERR until new_coefficient_set=0, then IDLE with load_err=0.

Optional Feature:
- Macro: COEFF_LOAD_TIMEOUT_EN.
- Defined:
  - An 8-bit counter resets on entry to each WAITn and increments each cycle modwait=1 in WAITn.
  - If it reaches TIMEOUT_CYCLES while modwait is still 1, the next state is ERR.
  - The counter saturates and never wraps.
- Not defined:
  - No counter and no ERR state is reachable; load_err is constant 0.
  - WAITn waits indefinitely for modwait=0.

Test Plan:
- Normal load: reset, set new_coefficient_set=1, modwait high for exactly 1 cycle after each strobe → load_coeff pulses with coefficient_num 0,1,2,3 in cycles 1,3,5,7; clear_new_coeff in cycle 9; busy high in cycles 1-9.
- Blocked start: new_coefficient_set=1 while modwait=1 for 10 cycles → no load_coeff and busy=0 throughout; first strobe (num=0) one cycle after modwait falls.
- Stretched wait: modwait held high 5 cycles after the num=1 strobe → coefficient_num stays 1 and no strobe; the num=2 strobe comes the cycle after modwait falls.
- Flag dropped mid-sequence: new_coefficient_set deasserted after the num=1 strobe → strobes 2 and 3 still issued, clear_new_coeff still pulses once.
- Reset mid-sequence: assert rst in WAIT2 → all outputs 0 immediately (asynchronous), no clear_new_coeff. Releasing rst with the flag still 1 restarts at num=0.
- Timeout (COEFF_LOAD_TIMEOUT_EN defined, TIMEOUT_CYCLES=16): modwait stuck high after the num=0 strobe → load_err=1 after 16 cycles, no further strobes; deasserting new_coefficient_set returns to IDLE with load_err=0.

Source files
------------

// File: rtl/coeff_load_sequencer_if.sv
// -----------------------------------------------------------------------------
// coeff_load_sequencer_if
// Handshake bundle between the coefficient-load sequencer, the bus-side
// coefficient register block and the FIR datapath controller.
//   master : the sequencer (drives strobes, samples flag/modwait)
//   slave  : the environment (register block + FIR controller)
// -----------------------------------------------------------------------------
interface coeff_load_sequencer_if;
    logic       new_coefficient_set;  // register block: new set written
    logic       modwait;              // FIR controller busy
    logic       load_coeff;           // strobe: latch selected coefficient
    logic [1:0] coefficient_num;      // coefficient register mux select
    logic       clear_new_coeff;      // pulse: clear new_coefficient_set
    logic       busy;                 // sequencer not idle
    logic       load_err;             // modwait timeout seen

    modport master (
        input  new_coefficient_set,
        input  modwait,
        output load_coeff,
        output coefficient_num,
        output clear_new_coeff,
        output busy,
        output load_err
    );

    modport slave (
        output new_coefficient_set,
        output modwait,
        input  load_coeff,
        input  coefficient_num,
        input  clear_new_coeff,
        input  busy,
        input  load_err
    );
endinterface

// File: rtl/coeff_load_sequencer.sv
// -----------------------------------------------------------------------------
// coeff_load_sequencer
// Walks the FIR controller through loading coefficients F0..F3: one
// load_coeff strobe per coefficient, waiting for modwait to drop between
// strobes, then a single clear_new_coeff pulse back to the register block.
//
// All outputs are registered and are a pure function of the registered
// state, so no input reaches an output combinationally.
//
// Optional build macro COEFF_LOAD_TIMEOUT_EN:
//   defined   - each WAIT state counts cycles of modwait=1; after
//               TIMEOUT_CYCLES such cycles the FSM parks in ERR (load_err=1)
//               until new_coefficient_set drops.
//   undefined - WAIT states wait indefinitely; load_err is tied low.
// -----------------------------------------------------------------------------
module coeff_load_sequencer #(
    parameter int NUM_COEFFS     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    coeff_load_sequencer_if.master  bus
);

    // The state encoding and the 2-bit coefficient index assume a fixed set
    // of four coefficients; the timeout counter is 8 bits wide.
    if (NUM_COEFFS != 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_params
        $error("coeff_load_sequencer: NUM_COEFFS must be 4 and TIMEOUT_CYCLES 1..255");
    end

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD0,
        ST_WAIT0,
        ST_LOAD1,
        ST_WAIT1,
        ST_LOAD2,
        ST_WAIT2,
        ST_LOAD3,
        ST_WAIT3,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       r_load_coeff;
    logic [1:0] r_coeff_num;
    logic       r_clear_new_coeff;
    logic       r_busy;
    logic       w_timeout;

    // ---------------------------------------------------------------------
    // State decode helpers, shared by next-state and output logic
    // ---------------------------------------------------------------------
    function automatic logic f_is_load(input state_t s);
        return (s == ST_LOAD0) || (s == ST_LOAD1) ||
               (s == ST_LOAD2) || (s == ST_LOAD3);
    endfunction

    function automatic logic f_is_wait(input state_t s);
        return (s == ST_WAIT0) || (s == ST_WAIT1) ||
               (s == ST_WAIT2) || (s == ST_WAIT3);
    endfunction

    // Coefficient index presented to the mux: held through LOADn/WAITn and
    // left at 3 in DONE so the last coefficient stays selected.
    function automatic logic [1:0] f_coeff_num(input state_t s);
        logic [1:0] num;
        num = 2'd0;
        case (s)
            ST_LOAD1, ST_WAIT1:          num = 2'd1;
            ST_LOAD2, ST_WAIT2:          num = 2'd2;
            ST_LOAD3, ST_WAIT3, ST_DONE: num = 2'd3;
            default:                     num = 2'd0;
        endcase
        return num;
    endfunction

`ifdef COEFF_LOAD_TIMEOUT_EN
    localparam logic [7:0] LP_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_wait_cnt;
    logic       r_load_err;

    // Timeout fires on the cycle the counter would reach TIMEOUT_CYCLES with
    // modwait still high; >= also covers a saturated counter.
    assign w_timeout = bus.modwait && (r_wait_cnt >= LP_TIMEOUT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state logic: start, per-coefficient handshake, clear and error exit
    always_comb begin
        // NOTE: default first so every path assigns w_next_state; without it
        // the missing branches would infer a latch.
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                // Never start while a sample is in flight.
                if (bus.new_coefficient_set && !bus.modwait) begin
                    w_next_state = ST_LOAD0;
                end
            end
            ST_LOAD0: w_next_state = ST_WAIT0;
            ST_LOAD1: w_next_state = ST_WAIT1;
            ST_LOAD2: w_next_state = ST_WAIT2;
            ST_LOAD3: w_next_state = ST_WAIT3;
            ST_WAIT0: begin
                if (!bus.modwait)   w_next_state = ST_LOAD1;
                else if (w_timeout) w_next_state = ST_ERR;
            end
            ST_WAIT1: begin
                if (!bus.modwait)   w_next_state = ST_LOAD2;
                else if (w_timeout) w_next_state = ST_ERR;
            end
            ST_WAIT2: begin
                if (!bus.modwait)   w_next_state = ST_LOAD3;
                else if (w_timeout) w_next_state = ST_ERR;
            end
            ST_WAIT3: begin
                if (!bus.modwait)   w_next_state = ST_DONE;
                else if (w_timeout) w_next_state = ST_ERR;
            end
            // Flag level is re-evaluated in IDLE, so a slow clear restarts.
            ST_DONE:  w_next_state = ST_IDLE;
            ST_ERR: begin
                if (!bus.new_coefficient_set) w_next_state = ST_IDLE;
            end
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // State register with outputs decoded from the next state, so each
    // registered output always matches the state it is registered alongside
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= ST_IDLE;
            r_load_coeff      <= 1'b0;
            r_coeff_num       <= 2'd0;
            r_clear_new_coeff <= 1'b0;
            r_busy            <= 1'b0;
`ifdef COEFF_LOAD_TIMEOUT_EN
            r_wait_cnt        <= 8'd0;
            r_load_err        <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_state           <= w_next_state;
            r_load_coeff      <= f_is_load(w_next_state);
            r_coeff_num       <= f_coeff_num(w_next_state);
            r_clear_new_coeff <= (w_next_state == ST_DONE);
            r_busy            <= (w_next_state != ST_IDLE);
`ifdef COEFF_LOAD_TIMEOUT_EN
            r_load_err        <= (w_next_state == ST_ERR);
            // LOADn always leads into WAITn, so clearing here restarts the
            // count on every WAIT entry; the count saturates at all-ones.
            if (f_is_load(r_state)) begin
                r_wait_cnt <= 8'd0;
            end else if (f_is_wait(r_state) && bus.modwait && (r_wait_cnt != 8'hFF)) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
`endif
        end
    end

    assign bus.load_coeff      = r_load_coeff;
    assign bus.coefficient_num = r_coeff_num;
    assign bus.clear_new_coeff = r_clear_new_coeff;
    assign bus.busy            = r_busy;
`ifdef COEFF_LOAD_TIMEOUT_EN
    assign bus.load_err        = r_load_err;
`else
    assign bus.load_err        = 1'b0;
`endif

endmodule

// File: tb/tb_coeff_load_sequencer.sv
// -----------------------------------------------------------------------------
// tb_coeff_load_sequencer
// Scoreboarded bench: each scenario pushes the strobes / clear pulse it
// expects (cycle, coefficient index, kind) and a negedge monitor pops and
// compares them as the DUT produces them. Cycle k of a sequence is the k-th
// clock after the start condition is presented.
// Build with +define+COEFF_LOAD_TIMEOUT_EN to exercise the timeout path.
// -----------------------------------------------------------------------------
module tb_coeff_load_sequencer;

    logic clk = 1'b0;
    logic rst;

    coeff_load_sequencer_if bus ();

    coeff_load_sequencer #(
        .NUM_COEFFS     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] num;
        logic       is_clear;
    } ev_t;

    ev_t exp_q[$];
    int  cyc     = 0;
    int  n_checks = 0;
    int  n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic push_ev(input int at, input logic [1:0] num, input logic is_clear);
        ev_t e;
        e.cyc      = at;
        e.num      = num;
        e.is_clear = is_clear;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every strobe or clear pulse must match the head
    // of the expectation queue in cycle, kind and coefficient index.
    always @(negedge clk) begin : mon
        ev_t e;
        if (bus.load_coeff === 1'b1 || bus.clear_new_coeff === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("event_cycle", cyc, e.cyc);
                check("event_is_clear", bus.clear_new_coeff, e.is_clear);
                check("event_is_strobe", bus.load_coeff, !e.is_clear);
                check("event_num", bus.coefficient_num, e.num);
            end
        end
    end

    // One full sequence starting at the current negedge. stretch_idx selects
    // a WAIT state in which modwait is held for stretch_len extra cycles
    // (-1 for none); drop_early drops the flag right after the num=1 strobe.
    // The controller model also raises modwait while each strobe is shown.
    task automatic drive_sequence(input int stretch_idx, input int stretch_len,
                                  input bit drop_early);
        int s[4];
        int c;
        int base;
        int exp_num;
        logic mw;
        s[0] = 1;
        for (int n = 1; n < 4; n++) begin
            s[n] = s[n-1] + 2 + (((n - 1) == stretch_idx) ? stretch_len : 0);
        end
        c    = s[3] + 2 + ((stretch_idx == 3) ? stretch_len : 0);
        base = cyc;
        for (int n = 0; n < 4; n++) push_ev(base + s[n], 2'(n), 1'b0);
        push_ev(base + c, 2'd3, 1'b1);
        bus.new_coefficient_set = 1'b1;
        bus.modwait             = 1'b0;
        for (int k = 1; k <= c + 1; k++) begin
            @(negedge clk);
            check("seq_busy", bus.busy, (k <= c));
            check("seq_load_err", bus.load_err, 1'b0);
            if (k <= c) begin
                exp_num = 0;
                for (int n = 0; n < 4; n++) if (k >= s[n]) exp_num = n;
                check("seq_coeff_num", bus.coefficient_num, exp_num);
            end
            mw = 1'b0;
            for (int n = 0; n < 4; n++) if (k == s[n]) mw = 1'b1;
            if (stretch_idx >= 0 && k > s[stretch_idx] && k <= s[stretch_idx] + stretch_len)
                mw = 1'b1;
            bus.modwait = mw;
            if (drop_early && k == s[1]) bus.new_coefficient_set = 1'b0;
            if (k == c) bus.new_coefficient_set = 1'b0;
        end
        check("seq_queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int base;
        rst                     = 1'b1;
        bus.new_coefficient_set = 1'b0;
        bus.modwait             = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_load_coeff", bus.load_coeff, 1'b0);
        check("rst_coeff_num", bus.coefficient_num, 2'd0);
        check("rst_clear", bus.clear_new_coeff, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_load_err", bus.load_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", bus.busy, 1'b0);

        // Normal load: strobes in cycles 1,3,5,7, clear in cycle 9
        drive_sequence(-1, 0, 1'b0);

        // Blocked start: flag up while a sample is in flight
        bus.new_coefficient_set = 1'b1;
        bus.modwait             = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("blocked_busy", bus.busy, 1'b0);
            check("blocked_strobe", bus.load_coeff, 1'b0);
        end
        drive_sequence(-1, 0, 1'b0);

        // Stretched wait after the num=1 strobe
        drive_sequence(1, 5, 1'b0);

        // Flag dropped right after the num=1 strobe
        drive_sequence(-1, 0, 1'b1);

        // Reset asserted in WAIT2 abandons the set without a clear pulse
        @(negedge clk);
        base = cyc;
        push_ev(base + 1, 2'd0, 1'b0);
        push_ev(base + 3, 2'd1, 1'b0);
        push_ev(base + 5, 2'd2, 1'b0);
        bus.new_coefficient_set = 1'b1;
        bus.modwait             = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bus.modwait = (k == 6);
        end
        check("wait2_coeff_num", bus.coefficient_num, 2'd2);
        check("wait2_busy", bus.busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_load_coeff", bus.load_coeff, 1'b0);
        check("async_rst_coeff_num", bus.coefficient_num, 2'd0);
        check("async_rst_clear", bus.clear_new_coeff, 1'b0);
        check("async_rst_busy", bus.busy, 1'b0);
        check("async_rst_load_err", bus.load_err, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_queue_drained", exp_q.size(), 0);
        bus.modwait = 1'b0;
        rst         = 1'b0;
        // Flag still high on release: a fresh sequence from num=0
        drive_sequence(-1, 0, 1'b0);

`ifdef COEFF_LOAD_TIMEOUT_EN
        // modwait stuck after the num=0 strobe: ERR once modwait has been
        // high for 16 WAIT cycles (cycles 2..17), so load_err shows in 18
        begin
            int first_err;
            first_err = -1;
            @(negedge clk);
            base = cyc;
            push_ev(base + 1, 2'd0, 1'b0);
            bus.new_coefficient_set = 1'b1;
            bus.modwait             = 1'b0;
            for (int k = 1; k <= 25; k++) begin
                @(negedge clk);
                if (first_err < 0 && bus.load_err === 1'b1) first_err = k;
                bus.modwait = 1'b1;
            end
            check("timeout_cycle", first_err, 18);
            check("err_busy", bus.busy, 1'b1);
            bus.modwait = 1'b0;
            repeat (3) @(negedge clk);
            check("err_held", bus.load_err, 1'b1);
            check("err_no_strobe_queue", exp_q.size(), 0);
            bus.new_coefficient_set = 1'b0;
            @(negedge clk);
            check("err_exit_load_err", bus.load_err, 1'b0);
            check("err_exit_busy", bus.busy, 1'b0);
        end
`else
        // Without the timeout, WAIT0 holds through 30 cycles of modwait
        drive_sequence(0, 30, 1'b0);
`endif

        repeat (2) @(negedge clk);
        check("final_queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard time bound in case the bench itself stalls
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
